idwt_2d: RTL and testbench

Inverse single-level 2-D Haar wavelet transform for 8x8 image blocks of 8-bit pixels, the reconstruction side of the image-compression datapath. It accepts the eight 64-bit coefficient rows produced by the forward DWT stage, streamed one row per beat. It buffers the full block, then emits eight reconstructed pixel rows, one per beat, under valid/ready handshakes on both sides.

---
 rtl/idwt_2d.sv | 119 +++++++++++
 tb/tb_idwt_2d.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/idwt_2d.sv
// Inverse single-level 2-D Haar transform for 8x8 blocks of 8-bit pixels.
// Buffers eight coefficient rows, then emits eight reconstructed pixel rows.
module idwt_2d #(
   parameter int PIX_W = 8,
   parameter int N     = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*PIX_W-1:0] in_row,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [N*PIX_W-1:0] out_row,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last
);

   typedef enum logic {LOAD, EMIT} state_e;

   state_e      state_q;
   logic [2:0]  cnt_q;
   logic [63:0] buf_q [8];
   logic [63:0] out_row_q;
   logic        out_valid_q;
   logic        out_last_q;

   logic [2:0]  row_sel;
   logic [63:0] lo, hi, recon;
   logic [9:0]  lk, hk;
   logic [9:0]  v [8];
   logic [10:0] s, d;

   function automatic logic [7:0] sat(input logic [10:0] x);
      if (x[10])            return 8'h00;
      else if (|x[9:8])     return 8'hFF;
      else                  return x[7:0];
   endfunction

   // Row loaded into the output register on the next load event:
   // row 0 when entering EMIT, otherwise the row after the current one.
   always_comb begin
      row_sel = (state_q == EMIT) ? cnt_q + 3'd1 : 3'd0;
      lo      = buf_q[{1'b0, row_sel[2:1]}];
      hi      = buf_q[{1'b1, row_sel[2:1]}];
      lk      = '0;
      hk      = '0;
      s       = '0;
      d       = '0;
      recon   = '0;
      for (int k = 0; k < 8; k++) begin
         v[k] = '0;
      end
      for (int k = 0; k < 8; k++) begin
         if (k < 4) lk = {2'b00, lo[8*k +: 8]};
         else       lk = {{2{lo[8*k+7]}}, lo[8*k +: 8]};
         hk   = {{2{hi[8*k+7]}}, hi[8*k +: 8]};
         v[k] = row_sel[0] ? lk - hk : lk + hk;
      end
      for (int k = 0; k < 4; k++) begin
         s = {v[k][9], v[k]} + {v[k+4][9], v[k+4]};
         d = {v[k][9], v[k]} - {v[k+4][9], v[k+4]};
         recon[16*k +: 8]   = sat(s);
         recon[16*k+8 +: 8] = sat(d);
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == LOAD && in_valid) begin
         buf_q[cnt_q] <= in_row;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         cnt_q       <= '0;
         out_row_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         unique case (state_q)
            LOAD: begin
               if (in_valid) begin
                  if (cnt_q == 3'd7) begin
                     state_q     <= EMIT;
                     cnt_q       <= '0;
                     out_row_q   <= recon;
                     out_valid_q <= 1'b1;
                     out_last_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 3'd1;
                  end
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (cnt_q == 3'd7) begin
                     state_q     <= LOAD;
                     cnt_q       <= '0;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                  end else begin
                     cnt_q      <= cnt_q + 3'd1;
                     out_row_q  <= recon;
                     out_last_q <= (cnt_q == 3'd6);
                  end
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   assign in_ready  = (state_q == LOAD);
   assign out_row   = out_row_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_idwt_2d.sv
// Scoreboard bench for idwt_2d: directed blocks with hand expectations,
// random blocks against an integer model, backpressure and resets.
module tb_idwt_2d;

   typedef logic [63:0] blk_t [8];
   typedef struct { logic [63:0] row; logic last; } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] in_row = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] out_row;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_last;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   idwt_2d dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_row    (in_row),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_row   (out_row),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int x);
      if (x < 0) return 0;
      if (x > 255) return 255;
      return x;
   endfunction

   function automatic blk_t model(input blk_t c);
      blk_t r;
      for (int j = 0; j < 8; j++) begin
         int v [8];
         int p = j / 2;
         r[j] = '0;
         for (int k = 0; k < 8; k++) begin
            logic [7:0] lb, hb;
            int l, h;
            lb = c[p][8*k +: 8];
            hb = c[p+4][8*k +: 8];
            l = (k < 4) ? int'(lb) : int'($signed(lb));
            h = int'($signed(hb));
            v[k] = (j % 2 == 0) ? l + h : l - h;
         end
         for (int k = 0; k < 4; k++) begin
            r[j][16*k +: 8]   = 8'(sat(v[k] + v[k+4]));
            r[j][16*k+8 +: 8] = 8'(sat(v[k] - v[k+4]));
         end
      end
      return r;
   endfunction

   // Drive n rows; expectations are queued only for a complete block.
   task automatic send(input blk_t c, input blk_t e, input int n);
      for (int i = 0; i < n; i++) begin
         in_row   = c[i];
         in_valid = 1'b1;
         @(negedge clk);
         check("in_ready_load", 64'(in_ready), 64'd1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_row   = '0;
      if (n == 8) begin
         for (int j = 0; j < 8; j++) sb.push_back('{e[j], j == 7});
      end
   endtask

   task automatic reset_now(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, "_in_ready"},  64'(in_ready),  64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_out_row"},   out_row,        64'd0);
      check({tag, "_out_last"},  64'(out_last),  64'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Collect one block; bp_row stalls that row 3 cycles, abort_row resets.
   task automatic drain(input int bp_row, input int abort_row);
      int got = 0;
      int cyc = 0;
      exp_t e;
      logic [63:0] held;
      out_ready = 1'b1;
      while (got < 8 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (out_valid) begin
            if (got == 0) check("first_latency", 64'(cyc), 64'd1);
            if (got == abort_row) begin
               #1;
               reset_now("rst_emit");
               return;
            end
            if (got == bp_row) begin
               out_ready = 1'b0;
               held = out_row;
               in_valid = 1'b1;
               in_row = 64'hDEAD_BEEF_0BAD_F00D;
               repeat (3) begin
                  @(negedge clk);
                  check("bp_valid",    64'(out_valid), 64'd1);
                  check("bp_row_hold", out_row,        held);
                  check("bp_last",     64'(out_last),  64'(got == 7));
                  check("emit_in_rdy", 64'(in_ready),  64'd0);
               end
               in_valid = 1'b0;
               in_row = '0;
               out_ready = 1'b1;
            end
            if (sb.size() == 0) begin
               check("sb_empty", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check($sformatf("row%0d", got), out_row, e.row);
               check($sformatf("last%0d", got), 64'(out_last), 64'(e.last));
            end
            got++;
         end
      end
      check("drain_timeout", 64'(got), 64'd8);
      @(posedge clk);
      #1;
      check("post_in_ready",  64'(in_ready),  64'd1);
      check("post_out_valid", 64'(out_valid), 64'd0);
      check("post_out_last",  64'(out_last),  64'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      blk_t c, e;

      #2;
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_row",   out_row,        64'd0);
      check("rst_out_last",  64'(out_last),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Flat block
      for (int i = 0; i < 8; i++) begin
         c[i] = (i < 4) ? 64'h0000_0000_8080_8080 : 64'h0;
         e[i] = 64'h8080_8080_8080_8080;
      end
      send(c, e, 8);
      drain(-1, -1);

      // Single HL coefficient
      for (int i = 0; i < 8; i++) begin c[i] = '0; e[i] = '0; end
      c[0] = 64'h0000_0005_0000_0010;
      e[0] = 64'h0B15;
      e[1] = 64'h0B15;
      send(c, e, 8);
      drain(-1, -1);

      // Saturation high / low
      c[0] = 64'h0000_007F_0000_00FF;
      e[0] = 64'h80FF;
      e[1] = 64'h80FF;
      send(c, e, 8);
      drain(-1, -1);
      c[0] = 64'h0000_0080_0000_0000;
      e[0] = 64'h8000;
      e[1] = 64'h8000;
      send(c, e, 8);
      drain(-1, -1);

      // Vertical pair
      for (int i = 0; i < 8; i++) begin c[i] = '0; e[i] = '0; end
      c[0] = 64'h40;
      c[4] = 64'h10;
      e[0] = 64'h5050;
      e[1] = 64'h3030;
      send(c, e, 8);
      drain(-1, -1);

      // Random block with backpressure on row 3 and in_valid during EMIT
      for (int i = 0; i < 8; i++) c[i] = {$urandom, $urandom};
      e = model(c);
      send(c, e, 8);
      drain(3, -1);

      // Reset after 5 input rows, then a fresh block
      for (int i = 0; i < 8; i++) c[i] = {$urandom, $urandom};
      send(c, e, 5);
      #2;
      reset_now("rst_load");
      for (int i = 0; i < 8; i++) c[i] = {$urandom, $urandom};
      e = model(c);
      send(c, e, 8);
      drain(-1, -1);

      // Reset during EMIT row 4, then a fresh block
      for (int i = 0; i < 8; i++) c[i] = {$urandom, $urandom};
      e = model(c);
      send(c, e, 8);
      drain(-1, 4);
      check("rst_emit_valid", 64'(out_valid), 64'd0);
      for (int i = 0; i < 8; i++) c[i] = {$urandom, $urandom};
      e = model(c);
      send(c, e, 8);
      drain(-1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
